uart_rx: RTL and testbench

//  Asynchronous serial receiver; far end of the uart_tx link (8N1 default, LSB first, idle high).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tick_gen.sv | 31 +++
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM states, baud divisor, 3-sample vote.
// Used by uart_rx and uart_tx; both derive the tick divisor from uart_divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    function automatic int uart_divisor(
        input int clock,
        input int baud,
        input int oversample
    );
        return (clock + baud * oversample / 2) / (baud * oversample);
    endfunction

    function automatic logic majority3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running clock divider: one-cycle tick every DIV clocks.
// Shared between uart_rx and uart_tx oversampling logic.
module uart_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output slot.
// Optional parity check built when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK      = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 inp_clock,
    input  logic                 inp_reset,
    input  logic                 inp_rxd,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 inp_ready,
    output logic                 out_ferr,
    output logic                 out_perr,
    output logic                 out_overrun
);

    localparam int DIV = uart_divisor(CLOCK, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_PRE  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_POST = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx: unsupported parameter set");
    end

    logic                 tick;
    logic                 sync1_q;
    logic                 sync2_q;
    uart_state_e          state_q;
    logic [SW-1:0]        s_q;
    logic [BW-1:0]        bit_q;
    logic [1:0]           smp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 done_q;
    logic                 ferr_q;
    logic                 maj;
    logic                 perr_frame;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    uart_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk_i (inp_clock),
        .rst_i (inp_reset),
        .tick_o(tick)
    );

    always_ff @(posedge inp_clock or posedge inp_reset) begin
        if (inp_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= inp_rxd;
            sync2_q <= sync1_q;
        end
    end

    // Third vote is the live sample taken on the S_POST tick itself.
    assign maj = majority3(smp_q[1], smp_q[0], sync2_q);

`ifdef UART_RX_PARITY_EN
    logic perr_lat_q;
    assign perr_frame = perr_lat_q;
`else
    assign perr_frame = 1'b0;
`endif

    always_ff @(posedge inp_clock or posedge inp_reset) begin
        if (inp_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_lat_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            if (tick) begin
                s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
                if (s_q == S_PRE) smp_q[1] <= sync2_q;
                if (s_q == S_MID) smp_q[0] <= sync2_q;
                unique case (state_q)
                    IDLE: begin
                        s_q <= '0;
                        if (!sync2_q) state_q <= START;
                    end
                    START: begin
                        if (s_q == S_POST && maj) begin
                            state_q <= IDLE;
                        end else if (s_q == S_LAST) begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end
                    end
                    DATA: begin
                        if (s_q == S_POST)
                            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                        if (s_q == S_LAST) begin
                            if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (s_q == S_POST)
                            perr_lat_q <= maj ^ (^shift_q) ^ 1'(PARITY_ODD);
                        if (s_q == S_LAST) state_q <= STOP;
                    end
`endif
                    // Decide at mid-stop so a back-to-back start edge is not missed.
                    STOP: begin
                        if (s_q == S_POST) begin
                            if (maj) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (sync2_q) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ovr_d   = 1'b0;
        if (done_q) begin
            if (!valid_q || inp_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = perr_frame;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (inp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge inp_clock or posedge inp_reset) begin
        if (inp_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_ferr    = ferr_q;
    assign out_perr    = perr_q;
    assign out_overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (432 clocks per bit).
// Parity cases are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int BIT_CLK = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ferr;
    logic       out_perr;
    logic       out_overrun;

    int n_checks = 0;
    int n_err    = 0;

    int         n_vcyc = 0;
    int         n_xfer = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_perr_v = 0;
    int         n_ovr  = 0;
    logic [7:0] last_data = 8'h00;

    always #10 clk = ~clk;

    uart_rx #(
        .CLOCK     (50000000),
        .BAUD      (115200),
        .OVERSAMPLE(16),
        .DATA_BITS (8),
        .PARITY_ODD(0)
    ) dut (
        .inp_clock  (clk),
        .inp_reset  (rst),
        .inp_rxd    (rxd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .inp_ready  (ready),
        .out_ferr   (out_ferr),
        .out_perr   (out_perr),
        .out_overrun(out_overrun)
    );

    always @(negedge clk) begin
        if (out_valid) n_vcyc++;
        if (out_valid && ready) begin
            n_xfer++;
            last_data = out_data;
        end
        if (out_ferr) n_ferr++;
        if (out_perr) n_perr++;
        if (out_perr && out_valid) n_perr_v++;
        if (out_overrun) n_ovr++;
    end

    initial begin
        #(200000 * 20);
        $display("FAIL watchdog: time limit expired, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par !== par) $display("unreachable");
`endif
        send_bit(stop);
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_data;
        int         exp_xfer;
        int         exp_vcyc;
        int         exp_flags;
    } vec_t;

    vec_t vecs[4];

    int         x0, v0, f0, p0, o0, pv0;
    logic [7:0] d;

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 1, 1, 0};
        vecs[1] = '{8'h81, 8'h81, 1, 1, 0};
        vecs[2] = '{8'h3C, 8'h3C, 1, 1, 0};
        vecs[3] = '{8'h0F, 8'h0F, 1, 1, 0};

        rst   = 1'b1;
        rxd   = 1'b1;
        ready = 1'b1;
        wait_clk(5);
        check("reset_data", int'(out_data), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_pulses", int'({out_ferr, out_perr, out_overrun}), 0);
        rst = 1'b0;
        wait_clk(BIT_CLK);

        for (int i = 0; i < 4; i++) begin
            x0 = n_xfer; v0 = n_vcyc;
            f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
            send_frame(vecs[i].data, 1'b1, ^vecs[i].data);
            wait_clk(100);
            check($sformatf("vec%0d_xfer", i), n_xfer - x0, vecs[i].exp_xfer);
            check($sformatf("vec%0d_data", i), int'(last_data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_vcyc", i), n_vcyc - v0, vecs[i].exp_vcyc);
            check($sformatf("vec%0d_flags", i),
                  (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), vecs[i].exp_flags);
        end

        // Back-to-back with consumer stalled: first byte held, others overrun.
        ready = 1'b0;
        x0 = n_xfer; o0 = n_ovr; f0 = n_ferr;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_clk(100);
        check("b2b_no_xfer", n_xfer - x0, 0);
        check("b2b_valid_held", int'(out_valid), 1);
        check("b2b_data_held", int'(out_data), 8'h00);
        check("b2b_overruns", n_ovr - o0, 2);
        check("b2b_no_ferr", n_ferr - f0, 0);
        ready = 1'b1;
        wait_clk(2);
        check("b2b_xfer", n_xfer - x0, 1);
        check("b2b_xfer_data", int'(last_data), 8'h00);
        check("b2b_valid_drop", int'(out_valid), 0);

        // Short low glitch on idle line.
        x0 = n_xfer; v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
        rxd = 1'b0;
        wait_clk(100);
        rxd = 1'b1;
        wait_clk(2 * BIT_CLK);
        check("glitch_no_valid", n_vcyc - v0, 0);
        check("glitch_no_flags", (n_ferr - f0) + (n_ovr - o0), 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clk(100);
        check("glitch_next_xfer", n_xfer - x0, 1);
        check("glitch_next_data", int'(last_data), 8'h5A);

        // Framing error followed by a 3-bit-time low line.
        x0 = n_xfer; v0 = n_vcyc; f0 = n_ferr;
        d = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        rxd = 1'b0;
        wait_clk(3 * BIT_CLK);
        rxd = 1'b1;
        wait_clk(BIT_CLK);
        check("ferr_pulses", n_ferr - f0, 1);
        check("ferr_no_valid", n_vcyc - v0, 0);
        send_frame(8'h12, 1'b1, ^8'h12);
        wait_clk(100);
        check("ferr_next_xfer", n_xfer - x0, 1);
        check("ferr_next_data", int'(last_data), 8'h12);
        check("ferr_no_more", n_ferr - f0, 1);

        // Reset during the data bits of 0x81.
        x0 = n_xfer;
        d = 8'h81;
        send_bit(1'b0);
        send_bit(d[0]);
        send_bit(d[1]);
        rst = 1'b1;
        rxd = 1'b1;
        wait_clk(3);
        check("rst_mid_data", int'(out_data), 0);
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_pulses", int'({out_ferr, out_perr, out_overrun}), 0);
        wait_clk(7);
        rst = 1'b0;
        wait_clk(BIT_CLK);
        send_frame(8'h42, 1'b1, ^8'h42);
        wait_clk(100);
        check("rst_only_one", n_xfer - x0, 1);
        check("rst_next_data", int'(last_data), 8'h42);

`ifdef UART_RX_PARITY_EN
        x0 = n_xfer; p0 = n_perr; pv0 = n_perr_v;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(100);
        check("par_good_xfer", n_xfer - x0, 1);
        check("par_good_perr", n_perr - p0, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(100);
        check("par_bad_xfer", n_xfer - x0, 2);
        check("par_bad_data", int'(last_data), 8'h07);
        check("par_bad_perr", n_perr - p0, 1);
        check("par_bad_with_valid", n_perr_v - pv0, 1);
`else
        check("perr_tied_low", n_perr, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
